// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: registered state, combinational
// datapath strobes and selects decoded from state, INSTRUCTION and FLAGS.
//   i_clock, i_reset (sync, active-high), i_INSTRUCTION[31:0], i_FLAGS[3:0]
//   o_* strobes (1b), o_ALUSrcA/B, o_ResultSrc, o_RegSrc (2b),
//   o_ALUop, o_ShiftType (3b), o_STATE (4b debug)
module multicycle_controller (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_INSTRUCTION,
    input  logic [3:0]  i_FLAGS,
    output logic        o_PCWrite,
    output logic        o_IRWrite,
    output logic        o_RegWrite,
    output logic        o_MemWrite,
    output logic        o_FlagUpdate,
    output logic        o_AdrSrc,
    output logic        o_A3Src,
    output logic        o_WD3Src,
    output logic [1:0]  o_ALUSrcA,
    output logic [1:0]  o_ALUSrcB,
    output logic [1:0]  o_ResultSrc,
    output logic [1:0]  o_RegSrc,
    output logic [2:0]  o_ALUop,
    output logic [2:0]  o_ShiftType,
    output logic [3:0]  o_STATE
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_CMPX   = 4'd10
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_i;
    logic [3:0] w_cmd;
    logic       w_l;
    logic       w_link;
    logic [1:0] w_sh;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_ok;
    logic [2:0] w_aluop;
    logic       w_unused;

    assign w_cond = i_INSTRUCTION[31:28];
    assign w_op   = i_INSTRUCTION[27:26];
    assign w_i    = i_INSTRUCTION[25];
    assign w_cmd  = i_INSTRUCTION[24:21];
    assign w_l    = i_INSTRUCTION[20];
    assign w_link = i_INSTRUCTION[24];
    assign w_sh   = i_INSTRUCTION[6:5];
    assign {w_n, w_z, w_c, w_v} = i_FLAGS;

    assign w_unused = ^{i_INSTRUCTION[19:7], i_INSTRUCTION[4:0]};

    always_comb begin
        w_cond_ok = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = !w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = !w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = !w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = !w_v;
            4'b1000: w_cond_ok = w_c && !w_z;
            4'b1001: w_cond_ok = !w_c || w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = !w_z && (w_n == w_v);
            4'b1101: w_cond_ok = w_z || (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_aluop = 3'b000;
        case (w_cmd)
            4'b0100: w_aluop = 3'b000;
            4'b0010: w_aluop = 3'b001;
            4'b1010: w_aluop = 3'b001;
            4'b0000: w_aluop = 3'b010;
            4'b1100: w_aluop = 3'b011;
            4'b1101: w_aluop = 3'b100;
            default: w_aluop = 3'b000;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (!w_cond_ok || w_op == 2'b11)
                    w_next = S_FETCH;
                else if (w_op == 2'b10)
                    w_next = S_BRANCH;
                else if (w_op == 2'b01)
                    w_next = S_MEMADR;
                else if (w_cmd == 4'b1010)
                    w_next = S_CMPX;
                else if (w_i)
                    w_next = S_EXECI;
                else
                    w_next = S_EXECR;
            end
            S_MEMADR: w_next = w_l ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    // Reset gates the decode so no strobe fires while state may still hold
    // an in-flight instruction.
    always_comb begin
        o_PCWrite    = 1'b0;
        o_IRWrite    = 1'b0;
        o_RegWrite   = 1'b0;
        o_MemWrite   = 1'b0;
        o_FlagUpdate = 1'b0;
        o_AdrSrc     = 1'b0;
        o_A3Src      = 1'b0;
        o_WD3Src     = 1'b0;
        o_ALUSrcA    = 2'b00;
        o_ALUSrcB    = 2'b00;
        o_ResultSrc  = 2'b00;
        o_RegSrc     = 2'b00;
        o_ALUop      = 3'b000;
        o_ShiftType  = 3'b111;
        o_STATE      = i_reset ? 4'd0 : r_state;
        if (!i_reset) begin
            case (r_state)
                S_FETCH: begin
                    o_IRWrite   = 1'b1;
                    o_PCWrite   = 1'b1;
                    o_ALUSrcB   = 2'b11;
                    o_ResultSrc = 2'b10;
                    o_RegSrc    = 2'b10;
                end
                S_DECODE: begin
                    if (w_op == 2'b10)
                        o_RegSrc = 2'b01;
                    else if (w_op == 2'b01 && !w_l)
                        o_RegSrc = 2'b10;
                end
                S_EXECR: begin
                    o_ALUSrcA    = 2'b01;
                    o_ALUop      = w_aluop;
                    o_ShiftType  = {1'b0, w_sh};
                    o_FlagUpdate = w_l;
                end
                S_EXECI: begin
                    o_ALUSrcA    = 2'b01;
                    o_ALUSrcB    = 2'b01;
                    o_ALUop      = w_aluop;
                    o_FlagUpdate = w_l;
                end
                S_ALUWB:  o_RegWrite = 1'b1;
                S_CMPX: begin
                    o_ALUSrcA    = 2'b01;
                    o_ALUSrcB    = w_i ? 2'b01 : 2'b00;
                    o_ALUop      = 3'b001;
                    o_FlagUpdate = 1'b1;
                end
                S_MEMADR: begin
                    o_ALUSrcA = 2'b01;
                    o_ALUSrcB = 2'b01;
                end
                S_MEMRD:  o_AdrSrc = 1'b1;
                S_MEMWB: begin
                    o_RegWrite  = 1'b1;
                    o_ResultSrc = 2'b01;
                end
                S_MEMWR: begin
                    o_AdrSrc   = 1'b1;
                    o_MemWrite = 1'b1;
                end
                S_BRANCH: begin
                    o_PCWrite   = 1'b1;
                    o_ALUSrcA   = 2'b01;
                    o_ALUSrcB   = 2'b01;
                    o_ResultSrc = 2'b10;
                    if (w_link) begin
                        o_RegWrite = 1'b1;
                        o_A3Src    = 1'b1;
                        o_WD3Src   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Expected vectors: {PCW,IRW,RegW,MemW,FlagU,AdrSrc,A3Src,WD3Src, SrcA,SrcB,ResSrc,RegSrc, ALUop, Shift, STATE}.
module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic        pcw, irw, regw, memw, flu, adr, a3, wd3;
    logic [1:0]  srca, srcb, ress, regs;
    logic [2:0]  aluop, shift;
    logic [3:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_INSTRUCTION(instr),
        .i_FLAGS      (flags),
        .o_PCWrite    (pcw),
        .o_IRWrite    (irw),
        .o_RegWrite   (regw),
        .o_MemWrite   (memw),
        .o_FlagUpdate (flu),
        .o_AdrSrc     (adr),
        .o_A3Src      (a3),
        .o_WD3Src     (wd3),
        .o_ALUSrcA    (srca),
        .o_ALUSrcB    (srcb),
        .o_ResultSrc  (ress),
        .o_RegSrc     (regs),
        .o_ALUop      (aluop),
        .o_ShiftType  (shift),
        .o_STATE      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [25:0] V_RST   = {8'b0000_0000, 8'b00_00_00_00, 3'b000, 3'b111, 4'd0};
    localparam logic [25:0] V_FETCH = {8'b1100_0000, 8'b00_11_10_10, 3'b000, 3'b111, 4'd0};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [25:0] exp);
        logic [25:0] obs;
        #1;
        obs = {pcw, irw, regw, memw, flu, adr, a3, wd3,
               srca, srcb, ress, regs, aluop, shift, state};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h0;
        flags = 4'b0000;
        chk("reset_defaults", V_RST);
        tick();
        rst = 1'b0;
        chk("fetch_after_reset", V_FETCH);

        // MOV R0,#13
        instr = 32'hE3A0000D;
        tick();
        chk("mov_decode", {8'b0, 8'b00_00_00_00, 3'b000, 3'b111, 4'd1});
        tick();
        chk("mov_execi", {8'b0, 8'b01_01_00_00, 3'b100, 3'b111, 4'd7});
        tick();
        chk("mov_aluwb", {8'b0010_0000, 8'b0, 3'b000, 3'b111, 4'd8});
        tick();
        chk("mov_fetch", V_FETCH);

        // B (AL)
        instr = 32'hEA000002;
        tick();
        chk("b_decode", {8'b0, 8'b00_00_00_01, 3'b000, 3'b111, 4'd1});
        tick();
        chk("b_branch", {8'b1000_0000, 8'b01_01_10_00, 3'b000, 3'b111, 4'd9});
        tick();
        chk("b_fetch", V_FETCH);

        // BEQ not taken
        instr = 32'h0A000002;
        flags = 4'b0000;
        tick();
        chk("beq_nt_decode", {8'b0, 8'b00_00_00_01, 3'b000, 3'b111, 4'd1});
        tick();
        chk("beq_nt_fetch", V_FETCH);

        // BEQ taken
        flags = 4'b0100;
        tick();
        chk("beq_t_decode", {8'b0, 8'b00_00_00_01, 3'b000, 3'b111, 4'd1});
        tick();
        chk("beq_t_branch", {8'b1000_0000, 8'b01_01_10_00, 3'b000, 3'b111, 4'd9});
        tick();
        chk("beq_t_fetch", V_FETCH);

        // BGT with N=V=1, Z=0 taken
        instr = 32'hCA000000;
        flags = 4'b1001;
        tick();
        tick();
        chk("bgt_branch", {8'b1000_0000, 8'b01_01_10_00, 3'b000, 3'b111, 4'd9});
        tick();
        flags = 4'b0000;

        // LDR
        instr = 32'hE5910000;
        tick();
        chk("ldr_decode", {8'b0, 8'b00_00_00_00, 3'b000, 3'b111, 4'd1});
        tick();
        chk("ldr_memadr", {8'b0, 8'b01_01_00_00, 3'b000, 3'b111, 4'd2});
        tick();
        chk("ldr_memrd", {8'b0000_0100, 8'b0, 3'b000, 3'b111, 4'd3});
        tick();
        chk("ldr_memwb", {8'b0010_0000, 8'b00_00_01_00, 3'b000, 3'b111, 4'd4});
        tick();
        chk("ldr_fetch", V_FETCH);

        // STR
        instr = 32'hE5810000;
        tick();
        chk("str_decode", {8'b0, 8'b00_00_00_10, 3'b000, 3'b111, 4'd1});
        tick();
        chk("str_memadr", {8'b0, 8'b01_01_00_00, 3'b000, 3'b111, 4'd2});
        tick();
        chk("str_memwr", {8'b0001_0100, 8'b0, 3'b000, 3'b111, 4'd5});
        tick();
        chk("str_fetch", V_FETCH);

        // CMP R0,R1
        instr = 32'hE1500001;
        tick();
        chk("cmp_decode", {8'b0, 8'b0, 3'b000, 3'b111, 4'd1});
        tick();
        chk("cmp_cmpx", {8'b0000_1000, 8'b01_00_00_00, 3'b001, 3'b111, 4'd10});
        tick();
        chk("cmp_fetch", V_FETCH);

        // BL
        instr = 32'hEB000001;
        tick();
        chk("bl_decode", {8'b0, 8'b00_00_00_01, 3'b000, 3'b111, 4'd1});
        tick();
        chk("bl_branch", {8'b1010_0011, 8'b01_01_10_00, 3'b000, 3'b111, 4'd9});
        tick();

        // SUBS R0,R1,R2 register form, flags updated
        instr = 32'hE0510002;
        tick();
        tick();
        chk("subs_execr", {8'b0000_1000, 8'b01_00_00_00, 3'b001, 3'b000, 4'd6});
        tick();
        chk("subs_aluwb", {8'b0010_0000, 8'b0, 3'b000, 3'b111, 4'd8});
        tick();

        // EOR immediate: unmapped cmd uses ALUop 000
        instr = 32'hE2200001;
        tick();
        tick();
        chk("eor_execi", {8'b0, 8'b01_01_00_00, 3'b000, 3'b111, 4'd7});
        tick();
        tick();

        // op=11 skipped
        instr = 32'hEC000000;
        tick();
        chk("op11_decode", {8'b0, 8'b0, 3'b000, 3'b111, 4'd1});
        tick();
        chk("op11_fetch", V_FETCH);

        // cond=1111 never executes
        instr = 32'hF3A0000D;
        tick();
        tick();
        chk("nv_fetch", V_FETCH);

        // ADD with ASR shift, reset hits during EXECR
        instr = 32'hE0810042;
        tick();
        tick();
        chk("add_execr", {8'b0, 8'b01_00_00_00, 3'b000, 3'b010, 4'd6});
        rst = 1'b1;
        chk("reset_in_execr", V_RST);
        tick();
        rst = 1'b0;
        chk("fetch_after_abort", V_FETCH);
        tick();
        chk("decode_after_abort", {8'b0, 8'b0, 3'b000, 3'b111, 4'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock is the only clock; reset is synchronous and active-high.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 INSTRUCTION  in  32  datapath INSTRUCTION_OUT, valid from DECODE onward.
REQ-005 FLAGS  in  4  datapath flags, with [3]=N, [2]=Z, [1]=C, [0]=V.
REQ-006 PCWrite, IRWrite, RegWrite, MemWrite, FlagUpdate, AdrSrc, A3Src, WD3Src  out  1 each  datapath strobes and selects.
REQ-007 ALUSrcA, ALUSrcB, ResultSrc, RegSrc  out  2 each  datapath selects.
REQ-008 ALUop  out  3  ALU operation code.
REQ-009 ShiftType  out  3  shifter type; 3'b111 means no shift.
REQ-010 STATE  out  4  current state code, for debug.

Function
REQ-011 State SHALL be registered; outputs SHALL be combinational from state, INSTRUCTION and FLAGS.
REQ-012 States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, CMPX=10.
REQ-013 Default outputs in every state: all strobes 0, all selects 0, ALUop=000, ShiftType=111.
REQ-014 Decode fields: cond=[31:28], op=[27:26], I=[25], cmd=[24:21], S/L=[20], branch-link=[24], sh=[6:5].
REQ-015 FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=11 (constant 4), ResultSrc=10, RegSrc=10, ALUop=000. Next state is always DECODE.
REQ-016 DECODE: RegSrc=01 if op=10; RegSrc=10 if op=01 and L=0; otherwise 00.
REQ-017 DECODE condition check uses cond and the FLAGS sampled in DECODE:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL (1110) is always true; 1111 is never true.
REQ-018 DECODE on condition false, or op=11: next state is FETCH; the instruction SHALL produce no PC, register, memory or flag write.
REQ-019 DECODE on condition true:
- op=10 goes to BRANCH.
- op=01 goes to MEMADR.
- op=00 with cmd=1010 (CMP) goes to CMPX.
- op=00 with I=1 goes to EXECI; with I=0 goes to EXECR.
REQ-020 ALUop map from cmd: 0100 ADD=000, 0010 SUB=001, 1010 CMP=001, 0000 AND=010, 1100 ORR=011, 1101 MOV=100. Any other cmd SHALL use 000.
REQ-021 EXECR: ALUSrcA=01, ALUSrcB=00, ALUop per map, ShiftType={0,sh}, FlagUpdate=S. Next state is ALUWB.
REQ-022 EXECI: ALUSrcA=01, ALUSrcB=01, ALUop per map, ShiftType=111, FlagUpdate=S. Next state is ALUWB.
REQ-023 ALUWB: RegWrite=1, ResultSrc=00, A3Src=0, WD3Src=0. Next state is FETCH.
REQ-024 CMPX: ALUSrcA=01, ALUSrcB=00 when I=0, 01 when I=1; ALUop=001, FlagUpdate=1, no RegWrite. Next state is FETCH.
REQ-025 MEMADR: ALUSrcA=01, ALUSrcB=01, ALUop=000. Next state is MEMRD if L=1, MEMWR if L=0.
REQ-026 MEMRD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
REQ-027 MEMWB: RegWrite=1, ResultSrc=01. Next state is FETCH.
REQ-028 MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1. Next state is FETCH.
REQ-029 BRANCH: PCWrite=1, ALUSrcA=01, ALUSrcB=01, ResultSrc=10, ALUop=000. If branch-link=1, also RegWrite=1, A3Src=1 (R14) and WD3Src=1 (PC). Next state is FETCH.
REQ-030 Latency per instruction:
- Data-processing: 4 cycles. CMP: 3. LDR: 5. STR: 4. B/BL: 3. Skipped: 2.
REQ-031 An illegal state encoding SHALL return to FETCH on the next edge.

Reset
REQ-032 While reset=1 at a rising edge, state SHALL become FETCH, overriding any in-flight instruction; no write strobe SHALL assert in the cycle reset is sampled high.
REQ-033 During the reset cycle, all outputs SHALL be at their defaults (REQ-013) and STATE=0.
REQ-034 In the first cycle after reset is released, the outputs SHALL be the FETCH values.

Verification
REQ-035 Reset 1 cycle, then INSTRUCTION=0xE3A0000D (MOV R0,#13) -> STATE 0,1,7,8,0; ALUop=100 in EXECI; RegWrite=1 only in ALUWB.
REQ-036 0xEA000002 (B, AL) -> STATE 0,1,9,0; PCWrite=1, ALUSrcA=01, ALUSrcB=01 in BRANCH; RegWrite=0.
REQ-037 0x0A000002 (BEQ) with FLAGS=0000 -> STATE 0,1,0; no PCWrite after FETCH. With FLAGS=0100 -> BRANCH entered.
REQ-038 0xE5910000 (LDR) -> states 0,1,2,3,4,0; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. 0xE5810000 (STR) -> MemWrite=1 only in MEMWR.
REQ-039 0xE1500001 (CMP R0,R1) -> STATE 0,1,10,0 with FlagUpdate=1, ALUop=001, RegWrite=0 throughout.
REQ-040 0xEB000001 (BL) -> BRANCH with RegWrite=1, A3Src=1, WD3Src=1. Reset asserted in EXECR -> next STATE=0 and no ALUWB write.
